// File: rtl/if_id_reg_if.sv
// Fetch-to-decode pipeline register bundle: F-side inputs, hazard/CP0 controls
// and the registered D-side outputs.
interface if_id_reg_if;
    logic        en;
    logic        flush;
    logic        req;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_bd;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exccode;
    logic        d_bd;
    logic        d_valid;
    logic [15:0] stall_cnt;

    modport master (
        output en, flush, req, f_pc, f_instr, f_bd,
        input  d_pc, d_instr, d_exccode, d_bd, d_valid, stall_cnt
    );

    modport slave (
        input  en, flush, req, f_pc, f_instr, f_bd,
        output d_pc, d_instr, d_exccode, d_bd, d_valid, stall_cnt
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with fetch address-error detection, stall/flush/
// redirect handling and a saturating stall-cycle counter.
module if_id_reg #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input logic         clk,
    input logic         reset,
    if_id_reg_if.slave  bus
);

    localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI   = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    // Power-up values match the reset values so D is a bubble before the first edge.
    logic [31:0] d_pc_q      = PC_RESET;
    logic [31:0] d_instr_q   = 32'h0;
    logic [4:0]  d_exccode_q = EXC_NONE;
    logic        d_bd_q      = 1'b0;
    logic        d_valid_q   = 1'b0;
    logic [15:0] stall_cnt_q = 16'h0;

    logic [31:0] d_pc_d;
    logic [31:0] d_instr_d;
    logic [4:0]  d_exccode_d;
    logic        d_bd_d;
    logic        d_valid_d;
    logic [15:0] stall_cnt_d;
    logic        fetch_err;

    assign fetch_err = (bus.f_pc[1:0] != 2'b00) || (bus.f_pc < IMEM_LO) || (bus.f_pc > IMEM_HI);

    always_comb begin
        d_pc_d      = d_pc_q;
        d_instr_d   = d_instr_q;
        d_exccode_d = d_exccode_q;
        d_bd_d      = d_bd_q;
        d_valid_d   = d_valid_q;
        stall_cnt_d = stall_cnt_q;

        if (bus.req) begin
            d_pc_d      = EXC_ENTRY;
            d_instr_d   = 32'h0;
            d_exccode_d = EXC_NONE;
            d_bd_d      = 1'b0;
            d_valid_d   = 1'b0;
        end else if (!bus.en) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else if (bus.flush) begin
            // A flushed slot keeps its PC and delay-slot flag but carries no work.
            d_pc_d      = bus.f_pc;
            d_instr_d   = 32'h0;
            d_exccode_d = EXC_NONE;
            d_bd_d      = bus.f_bd;
            d_valid_d   = 1'b0;
        end else begin
            d_pc_d      = bus.f_pc;
            d_instr_d   = fetch_err ? 32'h0 : bus.f_instr;
            d_exccode_d = fetch_err ? EXC_ADEL : EXC_NONE;
            d_bd_d      = bus.f_bd;
            d_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_pc_q      <= PC_RESET;
            d_instr_q   <= 32'h0;
            d_exccode_q <= EXC_NONE;
            d_bd_q      <= 1'b0;
            d_valid_q   <= 1'b0;
            stall_cnt_q <= 16'h0;
        end else begin
            d_pc_q      <= d_pc_d;
            d_instr_q   <= d_instr_d;
            d_exccode_q <= d_exccode_d;
            d_bd_q      <= d_bd_d;
            d_valid_q   <= d_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.d_pc      = d_pc_q;
    assign bus.d_instr   = d_instr_q;
    assign bus.d_exccode = d_exccode_q;
    assign bus.d_bd      = d_bd_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a monitor pops and compares on negedge.
module tb_if_id_reg;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cycle = 0;
    int   assertCount = 0;
    int   failCount   = 0;

    if_id_reg_if bus ();

    if_id_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          target;
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
        logic [15:0] stall;
    } exp_t;

    exp_t expQ[$];

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    task automatic checkEntry(input exp_t e);
        checkOutput(e.name, "d_pc",      bus.d_pc,              e.pc);
        checkOutput(e.name, "d_instr",   bus.d_instr,           e.instr);
        checkOutput(e.name, "d_exccode", {27'h0, bus.d_exccode}, {27'h0, e.exc});
        checkOutput(e.name, "d_bd",      {31'h0, bus.d_bd},      {31'h0, e.bd});
        checkOutput(e.name, "d_valid",   {31'h0, bus.d_valid},   {31'h0, e.valid});
        checkOutput(e.name, "stall_cnt", {16'h0, bus.stall_cnt}, {16'h0, e.stall});
    endtask

    // Monitor: compare the head entry once the edge it targets has passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].target <= cycle) begin
                e = expQ.pop_front();
                if (e.target < cycle) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL %s.missed actual=cycle %0d required=cycle %0d",
                             e.name, cycle, e.target);
                end else begin
                    checkEntry(e);
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic rst, input logic rq,
                                 input logic en, input logic fl,
                                 input logic [31:0] fpc, input logic [31:0] finstr,
                                 input logic fbd, input logic check,
                                 input logic [31:0] ePc, input logic [31:0] eInstr,
                                 input logic [4:0] eExc, input logic eBd,
                                 input logic eValid, input logic [15:0] eStall);
        exp_t e;
        reset       = rst;
        bus.req     = rq;
        bus.en      = en;
        bus.flush   = fl;
        bus.f_pc    = fpc;
        bus.f_instr = finstr;
        bus.f_bd    = fbd;
        if (check) begin
            e.target = cycle + 1;
            e.name   = name;
            e.pc     = ePc;
            e.instr  = eInstr;
            e.exc    = eExc;
            e.bd     = eBd;
            e.valid  = eValid;
            e.stall  = eStall;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req = 1'b0; bus.en = 1'b0; bus.flush = 1'b0;
        bus.f_pc = 32'h0; bus.f_instr = 32'h0; bus.f_bd = 1'b0;
        #1;
        checkEntry('{0, "powerup", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0, 16'h0});

        //             name        rst rq en fl f_pc        f_instr       bd chk  d_pc        d_instr       exc  bd  v   stall
        applyStimulus("reset",     1, 1, 1, 1, 32'h5000, 32'h1111_1111, 1, 1, 32'h3000, 32'h0,        5'd0, 0, 0, 16'd0);
        applyStimulus("load",      0, 0, 1, 0, 32'h3004, 32'h2401_0005, 0, 1, 32'h3004, 32'h2401_0005, 5'd0, 0, 1, 16'd0);
        applyStimulus("stall1",    0, 0, 0, 0, 32'h3008, 32'h2222_2222, 0, 1, 32'h3004, 32'h2401_0005, 5'd0, 0, 1, 16'd1);
        applyStimulus("stall2fl",  0, 0, 0, 1, 32'h3008, 32'h2222_2222, 1, 1, 32'h3004, 32'h2401_0005, 5'd0, 0, 1, 16'd2);
        applyStimulus("stall3",    0, 0, 0, 0, 32'h3008, 32'h2222_2222, 0, 1, 32'h3004, 32'h2401_0005, 5'd0, 0, 1, 16'd3);
        applyStimulus("misalign",  0, 0, 1, 0, 32'h3006, 32'hFFFF_FFFF, 0, 1, 32'h3006, 32'h0,        5'd4, 0, 1, 16'd3);
        applyStimulus("above",     0, 0, 1, 0, 32'h7000, 32'h1234_5678, 0, 1, 32'h7000, 32'h0,        5'd4, 0, 1, 16'd3);
        applyStimulus("topedge",   0, 0, 1, 0, 32'h6FFC, 32'hAABB_CCDD, 1, 1, 32'h6FFC, 32'hAABB_CCDD, 5'd0, 1, 1, 16'd3);
        applyStimulus("below",     0, 0, 1, 0, 32'h2FFC, 32'h3333_3333, 1, 1, 32'h2FFC, 32'h0,        5'd4, 1, 1, 16'd3);
        applyStimulus("botedge",   0, 0, 1, 0, 32'h3000, 32'h0000_0011, 0, 1, 32'h3000, 32'h0000_0011, 5'd0, 0, 1, 16'd3);
        applyStimulus("reqstall",  0, 1, 0, 1, 32'h3010, 32'h4444_4444, 1, 1, 32'h4180, 32'h0,        5'd0, 0, 0, 16'd3);
        applyStimulus("reqload",   0, 1, 1, 0, 32'h3014, 32'h5555_5555, 1, 1, 32'h4180, 32'h0,        5'd0, 0, 0, 16'd3);
        applyStimulus("flush",     0, 0, 1, 1, 32'h3020, 32'h0000_DEAD, 1, 1, 32'h3020, 32'h0,        5'd0, 1, 0, 16'd3);
        applyStimulus("flushbad",  0, 0, 1, 1, 32'h3022, 32'h6666_6666, 0, 1, 32'h3022, 32'h0,        5'd0, 0, 0, 16'd3);
        applyStimulus("holdbub",   0, 0, 0, 0, 32'h3030, 32'h7777_7777, 1, 1, 32'h3022, 32'h0,        5'd0, 0, 0, 16'd4);

        // 65539 unchecked stalls take the counter from 4 to 65543 -> saturated.
        for (int i = 0; i < 65539; i++) begin
            applyStimulus("longstall", 0, 0, 0, 0, 32'h3030, 32'h7777_7777, 1, 0,
                          32'h0, 32'h0, 5'd0, 0, 0, 16'd0);
        end
        applyStimulus("saturate",  0, 0, 0, 0, 32'h3030, 32'h7777_7777, 1, 1, 32'h3022, 32'h0,        5'd0, 0, 0, 16'hFFFF);
        applyStimulus("nowrap",    0, 0, 0, 1, 32'h3030, 32'h7777_7777, 1, 1, 32'h3022, 32'h0,        5'd0, 0, 0, 16'hFFFF);
        applyStimulus("midreset",  1, 0, 0, 0, 32'h3030, 32'h7777_7777, 1, 1, 32'h3000, 32'h0,        5'd0, 0, 0, 16'd0);
        applyStimulus("poststall", 0, 0, 0, 0, 32'h3040, 32'h8888_8888, 0, 1, 32'h3000, 32'h0,        5'd0, 0, 0, 16'd1);
        applyStimulus("postload",  0, 0, 1, 0, 32'h3040, 32'h8888_8888, 0, 1, 32'h3040, 32'h8888_8888, 5'd0, 0, 1, 16'd1);

        @(negedge clk);
        @(negedge clk);
        if (expQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain actual=%0d pending required=0 pending", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 SHALL have port: en  input  1  load enable from hazard unit; 0 = stall (hold).
REQ-004 SHALL have port: flush  input  1  insert bubble into D when en=1.
REQ-005 SHALL have port: req  input  1  exception/eret redirect from CP0; clears the stage unconditionally.
REQ-006 SHALL have port: f_pc  input  32  PC register output (fetch address).
REQ-007 SHALL have port: f_instr  input  32  instruction memory read data for f_pc.
REQ-008 SHALL have port: f_bd  input  1  fetched instruction sits in a branch delay slot.
REQ-009 SHALL have port: d_pc  output  32  registered PC for decode.
REQ-010 SHALL have port: d_instr  output  32  registered instruction for decode.
REQ-011 SHALL have port: d_exccode  output  5  registered fetch exception code; 0 = none, 4 = AdEL.
REQ-012 SHALL have port: d_bd  output  1  registered delay-slot flag.
REQ-013 SHALL have port: d_valid  output  1  1 = D holds a real fetched instruction, 0 = bubble.
REQ-014 SHALL have port: stall_cnt  output  16  count of stall cycles since reset.
REQ-015 SHALL have parameter: PC_RESET, 32'h00003000, reset/bubble PC.
REQ-016 SHALL have parameter: EXC_ENTRY, 32'h00004180, PC loaded on req.

Function
REQ-017 SHALL evaluate fetch error combinationally: AdEL when f_pc[1:0]!=0, or f_pc<32'h00003000, or f_pc>32'h00006FFC.
REQ-018 SHALL update per edge with priority reset > req > (en=0 hold) > flush > load.
REQ-019 SHALL on req=1: d_pc=EXC_ENTRY, d_instr=0, d_exccode=0, d_bd=0, d_valid=0, regardless of en and flush.
REQ-020 SHALL on req=0, en=0: hold all of d_pc, d_instr, d_exccode, d_bd, d_valid; flush ignored.
REQ-021 SHALL on req=0, en=1, flush=1: d_pc=f_pc, d_bd=f_bd, d_instr=0, d_exccode=0, d_valid=0.
REQ-022 SHALL on req=0, en=1, flush=0, no fetch error: d_pc=f_pc, d_instr=f_instr, d_bd=f_bd, d_exccode=0, d_valid=1.
REQ-023 SHALL on load with fetch error: d_pc=f_pc, d_instr=0 (nop), d_exccode=4, d_bd=f_bd, d_valid=1.
REQ-024 SHALL have latency of exactly one cycle from F inputs to D outputs on load.
REQ-025 SHALL increment stall_cnt by 1 on each edge with reset=0, req=0, en=0.
REQ-026 SHALL saturate stall_cnt at 16'hFFFF (no wrap).
REQ-027 SHALL not modify stall_cnt on req or flush; stall_cnt cleared only by reset.
REQ-028 SHALL drive all outputs directly from registers (no combinational path input->output).

Reset
REQ-029 SHALL on reset=1 at edge: d_pc=PC_RESET, d_instr=0, d_exccode=0, d_bd=0, d_valid=0, stall_cnt=0, overriding req, en, flush.
REQ-030 SHALL take reset effect on first edge with reset=1, including mid-stall; outputs before first edge are PC_RESET/zeros via initial values.

Verification
REQ-031 SHALL verify load: en=1, f_pc=0x3004, f_instr=0x24010005, f_bd=0 -> next edge d_pc=0x3004, d_instr=0x24010005, d_valid=1, d_exccode=0.
REQ-032 SHALL verify stall: after REQ-031, en=0 for 3 cycles with f_pc=0x3008 -> d_pc stays 0x3004, stall_cnt=3; flush=1 during stall has no effect.
REQ-033 SHALL verify misaligned fetch: en=1, f_pc=0x3006, f_instr=0xFFFFFFFF -> d_instr=0, d_exccode=4, d_valid=1; f_pc=0x7000 -> d_exccode=4.
REQ-034 SHALL verify req priority: req=1, en=0, flush=1, f_pc=0x3010 -> d_pc=0x4180, d_valid=0, stall_cnt unchanged.
REQ-035 SHALL verify flush: en=1, flush=1, f_pc=0x3020, f_bd=1 -> d_pc=0x3020, d_bd=1, d_instr=0, d_valid=0.
REQ-036 SHALL verify saturation and reset: en=0 for 65540 cycles -> stall_cnt=0xFFFF; then reset=1 one edge -> stall_cnt=0, d_pc=0x3000, d_valid=0.
